// File: rtl/instruction_encoder.sv
// instruction_encoder: sequential program loader.
// Takes symbolic instructions over a valid/ready stream, packs each one into
// an RV32I word and writes the words to consecutive instruction-memory
// addresses starting at 0. A HALT entry writes an all-zero word and ends the
// load. If memory fills before a HALT arrives, the load ends and overflow is
// set.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle pulse, starts a load (only from IDLE/DONE)
//   in_valid/in_ready instruction entry handshake
//   in_op             0=ADD 1=SUB 2=SW 3=LW 4=ADDI 5=LUI 6=JAL 7=HALT
//   in_rd/rs1/rs2     register fields
//   in_imm            immediate (12 or 20 bits used, depending on op)
//   mem_we/mem_wready memory write handshake; request held until accepted
//   mem_addr          word address of the current write
//   mem_wdata         encoded instruction word
//   busy              high while loading or writing
//   done              high once the load has completed
//   overflow          load ended by filling memory; sticky until start/rst
//   count             words written in the current load, HALT included
module instruction_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [19:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_LUI  = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [1:0]        state_q,     state_d;
  logic              in_ready_q,  in_ready_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              overflow_q,  overflow_d;
  logic [CNT_W-1:0]  count_q,     count_d;

  logic [31:0]       enc_c;
  logic              halt_word_c;

  // RV32I packing of the entry currently on the input bus
  always_comb begin
    enc_c = 32'h0000_0000;
    case (in_op)
      OP_ADD:  enc_c = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_OP};
      OP_SUB:  enc_c = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_OP};
      OP_SW:   enc_c = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
      OP_LW:   enc_c = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
      OP_ADDI: enc_c = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_OP_IMM};
      OP_LUI:  enc_c = {in_imm[19:0], in_rd, OPC_LUI};
      OP_JAL:  enc_c = {in_imm[19], in_imm[9:0], in_imm[10], in_imm[18:11], in_rd, OPC_JAL};
      OP_HALT: enc_c = 32'h0000_0000;
      default: enc_c = 32'h0000_0000;
    endcase
  end

  // Every real instruction carries a nonzero opcode, so a zero word is HALT
  assign halt_word_c = (mem_wdata_q == 32'h0000_0000);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    count_d     = count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // start wins over a same-cycle in_valid: nothing is accepted here
        if (start) begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          mem_addr_d = '0;
          count_d    = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          state_d     = S_WRITE;
          in_ready_d  = 1'b0;
          mem_we_d    = 1'b1;
          mem_wdata_d = enc_c;
        end
      end
      S_WRITE: begin
        if (mem_wready) begin
          mem_we_d = 1'b0;
          count_d  = count_q + CNT_W'(1);
          if (halt_word_c) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (mem_addr_q == ADDR_LAST) begin
            state_d    = S_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            overflow_d = 1'b1;
          end else begin
            state_d    = S_LOAD;
            in_ready_d = 1'b1;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
        mem_we_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: a full-size instance (ADDR_W=8) and a tiny
// one (ADDR_W=2) to reach the memory-full boundary.
module tb_instruction_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start_a, in_valid_a, in_ready_a, mem_we_a, wr_a;
  logic        busy_a, done_a, ovf_a;
  logic [2:0]  op_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [19:0] imm_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  count_a;

  logic        start_b, in_valid_b, in_ready_b, mem_we_b, wr_b;
  logic        busy_b, done_b, ovf_b;
  logic [2:0]  op_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [19:0] imm_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  instruction_encoder #(.ADDR_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .in_op(op_a), .in_rd(rd_a), .in_rs1(rs1_a),
    .in_rs2(rs2_a), .in_imm(imm_a), .mem_we(mem_we_a), .mem_wready(wr_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .count(count_a)
  );

  instruction_encoder #(.ADDR_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .in_op(op_b), .in_rd(rd_b), .in_rs1(rs1_b),
    .in_rs2(rs2_b), .in_imm(imm_b), .mem_we(mem_we_b), .mem_wready(wr_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .count(count_b)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        q_a[$];
  wr_t        q_b[$];
  wr_t        e_a, e_b;
  logic [7:0] next_addr_a;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Scoreboard monitors: a write is taken when mem_we and mem_wready are both high
  always @(negedge clk) begin
    if (!rst && mem_we_a && wr_a) begin
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write_a: got addr %0d data %h want none", addr_a, wdata_a);
      end else begin
        e_a = q_a.pop_front();
        chk("wr_addr_a", 32'(addr_a), 32'(e_a.addr));
        chk("wr_data_a", wdata_a, e_a.data);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_we_b && wr_b) begin
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write_b: got addr %0d data %h want none", addr_b, wdata_b);
      end else begin
        e_b = q_b.pop_front();
        chk("wr_addr_b", 32'(addr_b), 32'(e_b.addr));
        chk("wr_data_b", wdata_b, e_b.data);
      end
    end
  end

  task automatic pulse_start_a();
    next_addr_a = 8'd0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  // Offer one entry and return #1 after the edge that accepts it
  task automatic send_a(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [19:0] imm, input logic [31:0] exp);
    int n = 0;
    q_a.push_back({next_addr_a, exp});
    next_addr_a = next_addr_a + 8'd1;
    op_a = op; rd_a = rd; rs1_a = rs1; rs2_a = rs2; imm_a = imm;
    in_valid_a = 1'b1;
    while (!in_ready_a && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_a) timeout("accept_a");
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  task automatic wait_a(input bit for_done);
    int n = 0;
    while (!(for_done ? done_a : in_ready_a) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(for_done ? done_a : in_ready_a)) timeout(for_done ? "wait_done_a" : "wait_ready_a");
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready_a), 32'd0);
    chk({tag, "_mem_we"},   32'(mem_we_a),   32'd0);
    chk({tag, "_addr"},     32'(addr_a),     32'd0);
    chk({tag, "_wdata"},    wdata_a,         32'd0);
    chk({tag, "_busy"},     32'(busy_a),     32'd0);
    chk({tag, "_done"},     32'(done_a),     32'd0);
    chk({tag, "_overflow"}, 32'(ovf_a),      32'd0);
    chk({tag, "_count"},    32'(count_a),    32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 0; in_valid_a = 0; op_a = 0; rd_a = 0; rs1_a = 0; rs2_a = 0; imm_a = 0; wr_a = 1;
    start_b = 0; in_valid_b = 0; op_b = 0; rd_b = 0; rs1_b = 0; rs2_b = 0; imm_b = 0; wr_b = 1;
    next_addr_a = 8'd0;
    #12;
    chk_zero_a("reset");
    chk("reset_done_b", 32'(done_b), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load 1: start with in_valid high; only start acts in IDLE
    q_a.push_back({8'd0, 32'h002081B3});
    next_addr_a = 8'd1;
    op_a = 3'd0; rd_a = 5'd3; rs1_a = 5'd1; rs2_a = 5'd2; imm_a = 20'hFFFFF;
    start_a = 1'b1; in_valid_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("start_in_ready", 32'(in_ready_a), 32'd1);
    chk("start_no_accept", 32'(mem_we_a), 32'd0);
    chk("start_busy", 32'(busy_a), 32'd1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    chk("accept_mem_we", 32'(mem_we_a), 32'd1);
    @(posedge clk); #1;
    chk("after_write_in_ready", 32'(in_ready_a), 32'd1);
    chk("after_write_count", 32'(count_a), 32'd1);
    send_a(3'd1, 5'd3, 5'd1, 5'd2, 20'h00000, 32'h402081B3);
    wait_a(1'b0);
    chk("load1_count2", 32'(count_a), 32'd2);
    send_a(3'd7, 5'd9, 5'd9, 5'd9, 20'hABCDE, 32'h00000000);
    wait_a(1'b1);
    chk("load1_count3", 32'(count_a), 32'd3);

    // Load 2: memory ops and ADDI; upper imm bits must be ignored
    pulse_start_a();
    chk("restart_done_clr", 32'(done_a), 32'd0);
    chk("restart_count_clr", 32'(count_a), 32'd0);
    send_a(3'd3, 5'd5, 5'd1, 5'd31, 20'hFF008, 32'h0080A283);
    send_a(3'd2, 5'd31, 5'd1, 5'd2, 20'h0000C, 32'h0020A623);
    send_a(3'd4, 5'd1, 5'd0, 5'd7, 20'h00005, 32'h00500093);
    send_a(3'd7, 5'd0, 5'd0, 5'd0, 20'h00000, 32'h00000000);
    wait_a(1'b1);
    chk("load2_count", 32'(count_a), 32'd4);

    // Load 3: LUI, JAL, HALT
    pulse_start_a();
    send_a(3'd5, 5'd7, 5'd3, 5'd3, 20'h12345, 32'h123453B7);
    send_a(3'd6, 5'd1, 5'd3, 5'd3, 20'h00004, 32'h008000EF);
    send_a(3'd7, 5'd0, 5'd0, 5'd0, 20'h00000, 32'h00000000);
    wait_a(1'b1);
    chk("load3_done", 32'(done_a), 32'd1);
    chk("load3_count", 32'(count_a), 32'd3);
    chk("load3_busy", 32'(busy_a), 32'd0);
    chk("load3_overflow", 32'(ovf_a), 32'd0);
    chk("load3_in_ready", 32'(in_ready_a), 32'd0);

    // Load 4: three cycles of backpressure on the first write
    pulse_start_a();
    wr_a = 1'b0;
    send_a(3'd4, 5'd1, 5'd0, 5'd0, 20'h00005, 32'h00500093);
    for (int i = 0; i < 4; i++) begin
      chk("bp_mem_we", 32'(mem_we_a), 32'd1);
      chk("bp_addr", 32'(addr_a), 32'd0);
      chk("bp_wdata", wdata_a, 32'h00500093);
      chk("bp_in_ready", 32'(in_ready_a), 32'd0);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    wr_a = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready_a), 32'd1);
    chk("bp_release_mem_we", 32'(mem_we_a), 32'd0);
    chk("bp_release_count", 32'(count_a), 32'd1);
    send_a(3'd7, 5'd0, 5'd0, 5'd0, 20'h00000, 32'h00000000);
    chk("bp_next_accepted", 32'(mem_we_a), 32'd1);
    chk("bp_next_addr", 32'(addr_a), 32'd1);
    wait_a(1'b1);

    // Load 5: reset in the middle of a stalled write
    pulse_start_a();
    wr_a = 1'b0;
    send_a(3'd0, 5'd3, 5'd1, 5'd2, 20'h00000, 32'h002081B3);
    chk("pre_rst_mem_we", 32'(mem_we_a), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero_a("midrst");
    q_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    wr_a = 1'b1;
    pulse_start_a();
    send_a(3'd7, 5'd0, 5'd0, 5'd0, 20'h00000, 32'h00000000);
    wait_a(1'b1);
    chk("post_rst_count", 32'(count_a), 32'd1);

    // Small memory: five entries offered, only four fit
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 4; i++) q_b.push_back({8'(i), 32'h002081B3});
    op_b = 3'd0; rd_b = 5'd3; rs1_b = 5'd1; rs2_b = 5'd2;
    in_valid_b = 1'b1;
    begin
      int n = 0;
      while (!done_b && n < 60) begin
        @(posedge clk); #1;
        n++;
      end
      if (!done_b) timeout("wait_done_b");
    end
    chk("ovf_flag", 32'(ovf_b), 32'd1);
    chk("ovf_done", 32'(done_b), 32'd1);
    chk("ovf_count", 32'(count_b), 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_in_ready", 32'(in_ready_b), 32'd0);
      chk("ovf_mem_we", 32'(mem_we_b), 32'd0);
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("ovf_restart_flag", 32'(ovf_b), 32'd0);
    chk("ovf_restart_count", 32'(count_b), 32'd0);
    chk("ovf_restart_done", 32'(done_b), 32'd0);
    chk("ovf_restart_in_ready", 32'(in_ready_b), 32'd1);

    chk("queue_a_empty", 32'(q_a.size()), 32'd0);
    chk("queue_b_empty", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Sequential program loader: the encode side of the CPU's instruction set. Accepts symbolic instructions (op code plus register/immediate fields) over a valid/ready stream, packs each into a 32-bit RV32I word, and writes the words to consecutive instruction-memory locations from address 0. The decoder then executes them. A HALT entry writes an all-zero word, which the decoder treats as stop, and completes the load.

## Interface
- ADDR_W, 8, instruction-memory word-address width; depth 2^ADDR_W words
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE
- in_valid  in  1  instruction entry valid
- in_ready  out  1  encoder can accept an entry
- in_op  in  3  0=ADD 1=SUB 2=SW 3=LW 4=ADDI 5=LUI 6=JAL 7=HALT
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_imm  in  20  immediate: [11:0] for LW/SW/ADDI, [19:0] for LUI (upper 20), [19:0] for JAL (offset[20:1])
- mem_we  out  1  write request, held until accepted
- mem_wready  in  1  memory accepts write when high with mem_we
- mem_addr  out  ADDR_W  word address of current write
- mem_wdata  out  32  encoded instruction
- busy  out  1  high in LOAD/WRITE
- done  out  1  high in DONE
- overflow  out  1  load ended by filling memory without HALT; sticky until start or rst
- count  out  ADDR_W+1  words written in current load, including HALT word

## Operation
- Reset values: all outputs 0; state IDLE.
- FSM states: IDLE, LOAD, WRITE, DONE.
  - IDLE/DONE + start -> LOAD; mem_addr, count, overflow, done cleared.
  - LOAD: in_ready=1. On in_valid&in_ready, register the encoded word into mem_wdata -> WRITE.
  - WRITE: mem_we=1; mem_addr and mem_wdata held stable. On mem_we&mem_wready, count+=1, then:
    - HALT word -> DONE.
    - mem_addr == 2^ADDR_W-1 -> DONE, overflow=1.
    - otherwise mem_addr+=1 -> LOAD.
  - DONE: done=1; in_ready=0; start restarts.
- Encoding (standard RV32I; unused fields are 0):
  - ADD: {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011}.
  - SUB: same as ADD with funct7=7'b0100000.
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}.
  - ADDI: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - LUI: {imm[19:0], rd, 7'b0110111}.
  - JAL: {imm[19], imm[9:0], imm[10], imm[18:11], rd, 7'b1101111}.
  - HALT: 32'h0000_0000.
- Field handling: in_imm bits above the used width are ignored. Register inputs not used by an op are ignored.
- in_valid while in_ready=0 is not consumed; the source holds the entry.

## Timing
- Accept at edge N -> mem_we=1 and mem_wdata valid from N+1.
- mem_wready high at N+1 -> in_ready=1 from N+2. Peak throughput is one instruction per 2 cycles.
- Each cycle with mem_wready low adds one cycle.
- start during LOAD/WRITE is ignored. start and in_valid in the same cycle in IDLE: only start acts; no entry is accepted that cycle.
- rst asserted anywhere, including mid-WRITE, immediately returns IDLE with outputs 0. Memory contents already written are not touched.
- count and mem_addr update in the same edge as the completing write.

## Test plan
- ADD rd=3 rs1=1 rs2=2 with mem_wready=1 -> addr 0 gets 32'h002081B3. SUB with same fields -> addr 1 gets 32'h402081B3. count=2.
- LW rd=5 rs1=1 imm=8 -> 32'h0080A283. SW rs1=1 rs2=2 imm=12 -> 32'h0020A623. ADDI rd=1 rs1=0 imm=5 -> 32'h00500093.
- LUI rd=7 imm=20'h12345 -> 32'h123453B7. JAL rd=1 imm=20'h00004 -> 32'h008000EF. HALT -> 32'h00000000, done=1, count=3, busy=0.
- Backpressure: hold mem_wready=0 for 3 cycles during a write -> mem_we, mem_addr and mem_wdata stable for 4 cycles. in_ready=0 throughout; the next entry is accepted on the cycle after the write completes.
- ADDR_W=2, five non-HALT entries offered -> four writes at addr 0..3, then overflow=1 and done=1. The fifth entry is never accepted (in_ready=0). A later start clears overflow and count.
- Assert rst while mem_we=1 and mem_wready=0 -> all outputs 0 in the same cycle. A subsequent start and HALT writes 0 at addr 0.
